odd_even_sort_ctrl: RTL and testbench

ODD_EVEN_SORT_CTRL -- requirements
Module: odd_even_sort_ctrl

---
 rtl/odd_even_sort_ctrl_pkg.sv | 13 +
 rtl/odd_even_sort_ctrl_if.sv | 39 +++
 rtl/cmp_swap_cell.sv | 16 +
 rtl/odd_even_sort_ctrl.sv | 140 ++++++++++++++
 tb/tb_odd_even_sort_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/odd_even_sort_ctrl_pkg.sv
// Shared types and default sizing for the odd-even transposition sorter.
package odd_even_sort_ctrl_pkg;

    localparam int DEF_N = 8;
    localparam int DEF_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/odd_even_sort_ctrl_if.sv
// Load/drain bus of the sorter plus its status flags.
// Valid/ready: a word moves on every rising clk where valid and ready are both 1;
// the sender holds data stable while valid is high and ready is low.
interface odd_even_sort_ctrl_if #(
    parameter int W = 8
) ();

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;
    logic         sort_done;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  busy,
        input  sort_done
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output busy,
        output sort_done
    );

endinterface

// File: rtl/cmp_swap_cell.sv
// Unsigned compare-and-swap of one adjacent pair; equal values pass straight through.
module cmp_swap_cell #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi,
    output logic         swapped
);

    assign swapped = (a > b);
    assign lo      = swapped ? b : a;
    assign hi      = swapped ? a : b;

endmodule

// File: rtl/odd_even_sort_ctrl.sv
// Loads N words, sorts them ascending with one odd-even transposition phase per
// cycle, then drains them in order over a valid/ready stream.
module odd_even_sort_ctrl
    import odd_even_sort_ctrl_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic                 clk,
    input  logic                 reset,
    odd_even_sort_ctrl_if.slave  bus,
    output state_e               state_o
);

    localparam int             IW   = $clog2(N);
    localparam logic [IW-1:0]  LAST = IW'(N - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] phase_q, phase_d;
    logic          swap_prev_q, swap_prev_d;
    logic [W-1:0]  slot_q [N];
    logic [W-1:0]  slot_d [N];

    logic [W-1:0]  cell_lo [N-1];
    logic [W-1:0]  cell_hi [N-1];
    logic [N-2:0]  cell_sw;
    logic [W-1:0]  phase_out [N];
    logic          phase_swapped;
    logic          sort_exit;
    logic          in_fire;
    logic          out_fire;

    for (genvar i = 0; i < N - 1; i++) begin : g_cell
        cmp_swap_cell #(.W(W)) u_cell (
            .a       (slot_q[i]),
            .b       (slot_q[i+1]),
            .lo      (cell_lo[i]),
            .hi      (cell_hi[i]),
            .swapped (cell_sw[i])
        );
    end

    // Even phases take cells 0,2,4..; odd phases take cells 1,3,5..; the
    // selected pairs never overlap, so each slot has at most one writer.
    always_comb begin
        phase_out     = slot_q;
        phase_swapped = 1'b0;
        for (int i = 0; i < N - 1; i++) begin
            if ((i % 2) == int'(phase_q[0])) begin
                phase_out[i]   = cell_lo[i];
                phase_out[i+1] = cell_hi[i];
                phase_swapped  = phase_swapped | cell_sw[i];
            end
        end
    end

    // Two consecutive quiet phases cover both pair alignments: the array is sorted.
    assign sort_exit = (state_q == ST_SORT) &&
                       ((phase_q == LAST) ||
                        ((phase_q != '0) && !phase_swapped && !swap_prev_q));

    assign in_fire  = (state_q == ST_IDLE)  && bus.in_valid;
    assign out_fire = (state_q == ST_DRAIN) && bus.out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            phase_q     <= '0;
            swap_prev_q <= 1'b0;
            for (int i = 0; i < N; i++) slot_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            phase_q     <= phase_d;
            swap_prev_q <= swap_prev_d;
            slot_q      <= slot_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        phase_d     = phase_q;
        swap_prev_d = swap_prev_q;
        slot_d      = slot_q;
        case (state_q)
            ST_IDLE: begin
                if (in_fire) begin
                    slot_d[idx_q] = bus.in_data;
                    if (idx_q == LAST) begin
                        idx_d       = '0;
                        phase_d     = '0;
                        swap_prev_d = 1'b0;
                        state_d     = ST_SORT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_SORT: begin
                slot_d      = phase_out;
                swap_prev_d = phase_swapped;
                if (sort_exit) begin
                    phase_d = '0;
                    state_d = ST_DRAIN;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (out_fire) begin
                    if (idx_q == LAST) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                phase_d = '0;
            end
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE);
        bus.out_valid = (state_q == ST_DRAIN);
        bus.out_data  = (state_q == ST_DRAIN) ? slot_q[idx_q] : '0;
        bus.busy      = (state_q != ST_IDLE);
        bus.sort_done = sort_exit;
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_odd_even_sort_ctrl.sv
// Bench for odd_even_sort_ctrl: directed and random jobs against a sorting model.
module tb_odd_even_sort_ctrl;
    import odd_even_sort_ctrl_pkg::*;

    localparam int N = 8;
    localparam int W = 8;

    logic   clk;
    logic   reset;
    state_e state_dbg;

    odd_even_sort_ctrl_if #(.W(W)) bus ();

    odd_even_sort_ctrl #(.N(N), .W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .state_o (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Number of SORT cycles from the phase rules, run on a plain array.
    function automatic int model_sort_cycles(input logic [W-1:0] v[N]);
        logic [W-1:0] a[N];
        logic [W-1:0] t;
        bit           sw, prev;
        a    = v;
        prev = 1'b0;
        for (int p = 0; p < N; p++) begin
            sw = 1'b0;
            for (int i = p % 2; i + 1 < N; i += 2) begin
                if (a[i] > a[i+1]) begin
                    t = a[i]; a[i] = a[i+1]; a[i+1] = t;
                    sw = 1'b1;
                end
            end
            if (p == N - 1 || (p >= 1 && !sw && !prev)) return p + 1;
            prev = sw;
        end
        return N;
    endfunction

    // ---------------- driver tasks ----------------
    // All tasks start and end on a falling edge.
    task automatic load_job(input logic [W-1:0] vals[N], input int stall_at);
        for (int i = 0; i < N; i++) begin
            if (i == stall_at) begin
                bus.in_valid = 1'b0;
                repeat (40) @(negedge clk);
                check_eq("partial_wait_state", state_dbg, ST_IDLE);
                check_eq("partial_wait_ready", bus.in_ready, 1);
            end
            while ($urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_data  = W'($urandom);
                @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = vals[i];
            check_eq("load_in_ready", bus.in_ready, 1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_sort(input int exp_cycles, input bit keep_valid, output bit ok);
        int cycles = 0;
        int pulses = 0;
        int guard  = 0;
        ok = 1'b1;
        while (!bus.out_valid) begin
            if (keep_valid) begin
                bus.in_valid = 1'b1;
                bus.in_data  = W'($urandom);
            end
            check_eq("sort_in_ready", bus.in_ready, 0);
            if (bus.sort_done) pulses++;
            if (bus.busy) cycles++;
            @(negedge clk);
            guard++;
            if (guard > 4 * N) begin
                check_eq("sort_timeout", guard, 4 * N);
                ok = 1'b0;
                return;
            end
        end
        check_eq("sort_cycles", cycles, exp_cycles);
        check_eq("sort_done_pulses", pulses, 1);
    endtask

    task automatic drain_job(input int pattern, input bit keep_valid);
        int t = 0;
        for (int k = 0; k < N; k++) begin
            bit got   = 1'b0;
            int guard = 0;
            while (!got) begin
                bit rdy;
                case (pattern)
                    0:       rdy = 1'b1;
                    1:       rdy = (t % 3 == 0);
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                t++;
                bus.out_ready = rdy;
                if (keep_valid) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = W'($urandom);
                end
                check_eq("drain_valid", bus.out_valid, 1);
                check_eq("drain_data", bus.out_data, exp_q[0]);
                check_eq("drain_in_ready", bus.in_ready, 0);
                @(negedge clk);
                if (rdy) got = 1'b1;
                guard++;
                if (!got && guard > 64) begin
                    check_eq("drain_timeout", guard, 64);
                    exp_q.delete();
                    return;
                end
            end
            void'(exp_q.pop_front());
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check_eq("after_drain_in_ready", bus.in_ready, 1);
        check_eq("after_drain_out_valid", bus.out_valid, 0);
        check_eq("after_drain_busy", bus.busy, 0);
        check_eq("after_drain_state", state_dbg, ST_IDLE);
    endtask

    task automatic run_job(input logic [W-1:0] vals[N], input int pattern,
                           input bit keep_valid, input int fixed_cycles, input int stall_at);
        bit ok;
        int mc;
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(vals[i]);
        exp_q.sort();
        mc = model_sort_cycles(vals);
        if (fixed_cycles > 0) check_eq("model_cycles", mc, fixed_cycles);
        load_job(vals, stall_at);
        wait_sort(mc, keep_valid, ok);
        if (ok) drain_job(pattern, keep_valid);
        else exp_q.delete();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"}, bus.in_ready, 1);
        check_eq({tag, "_out_valid"}, bus.out_valid, 0);
        check_eq({tag, "_out_data"}, bus.out_data, 0);
        check_eq({tag, "_busy"}, bus.busy, 0);
        check_eq({tag, "_sort_done"}, bus.sort_done, 0);
        check_eq({tag, "_state"}, state_dbg, ST_IDLE);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] v[N];
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        v = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        run_job(v, 0, 1'b0, 8, -1);

        v = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        run_job(v, 0, 1'b0, 2, -1);

        v = '{8'd5, 8'd5, 8'd3, 8'd5, 8'd3, 8'd3, 8'd9, 8'd0};
        run_job(v, 0, 1'b0, 0, 3);

        for (int i = 0; i < N; i++) v[i] = W'($urandom);
        run_job(v, 1, 1'b0, 0, -1);

        for (int i = 0; i < N; i++) v[i] = W'($urandom);
        run_job(v, 2, 1'b1, 0, -1);

        // Reset in the middle of SORT, then a clean job.
        v = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        load_job(v, -1);
        repeat (3) @(negedge clk);
        check_eq("pre_reset_busy", bus.busy, 1);
        reset = 1'b0;
        #1;
        check_reset_outputs("midsort_reset");
        @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_eq("post_reset_out_valid", bus.out_valid, 0);
        end
        v = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        run_job(v, 0, 1'b0, 0, -1);

        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < N; i++) v[i] = W'($urandom_range(0, (j % 2) ? 3 : 255));
            run_job(v, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
